uart_rx_core: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_rx_core.sv | 130 +++++++++++++
 tb/tb_uart_rx_core.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing helpers.
// The TX block will reuse the period/half helpers.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  function automatic int unsigned uart_period(input int unsigned clk_rate,
                                              input int unsigned baud_rate);
    return clk_rate / baud_rate;
  endfunction

  function automatic int unsigned uart_half(input int unsigned clk_rate,
                                            input int unsigned baud_rate);
    return uart_period(clk_rate, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter; tick marks terminal count while the receiver is active.
module uart_bit_timer #(
  parameter int unsigned TW = 5
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          active_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          tick_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  assign tick_o = active_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (active_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive framer: times the start bit, samples data bits mid-bit with
// re-centring on data edges, checks the stop bit and pulses done or err.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_RATE   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_i,
  input  logic                  rise_i,
  input  logic                  fall_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int unsigned PERIOD = uart_period(CLK_RATE, BAUD_RATE);
  localparam int unsigned HALF   = uart_half(CLK_RATE, BAUD_RATE);
  localparam int unsigned TW     = $clog2(PERIOD + 1);
  localparam int unsigned CW     = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] RELOAD  = TW'(PERIOD - 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
  localparam logic [CW-1:0] LAST    = CW'(DATA_WIDTH - 1);

  if (PERIOD < 4) begin : g_period_chk
    $error("uart_rx_core: CLK_RATE/BAUD_RATE must be at least 4");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_width_chk
    $error("uart_rx_core: DATA_WIDTH must be 5..9");
  end

  rx_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  tick;
  logic                  tmr_load;
  logic [TW-1:0]         tmr_val;

  uart_bit_timer #(.TW(TW)) u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .active_i   (state_q != IDLE),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_o     (tick)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = RELOAD;
    unique case (state_q)
      IDLE: begin
        if (fall_i) begin
          state_d  = START;
          tmr_load = 1'b1;
          tmr_val  = HALF_M1;
        end
      end
      START: begin
        if (tick) begin
          tmr_load = 1'b1;
          cnt_d    = '0;
          state_d  = in_i ? IDLE : DATA;
        end
      end
      DATA: begin
        // A sample tick wins over a same-cycle edge so the bit is never lost.
        if (tick) begin
          tmr_load = 1'b1;
          shift_d  = {in_i, shift_q[DATA_WIDTH-1:1]};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = STOP;
        end else if (rise_i || fall_i) begin
          tmr_load = 1'b1;
          tmr_val  = HALF_M1;
        end
      end
      STOP: begin
        if (tick) begin
          tmr_load = 1'b1;
          state_d  = IDLE;
          if (in_i) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign data_o = data_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at PERIOD=16 with a bench-side edge synchronizer
// and a scoreboard of expected done/err events.
module tb_uart_rx_core;

  localparam int BITLEN = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       line = 1'b1;
  logic       s1 = 1'b1, s2 = 1'b1, s3 = 1'b1;
  logic       in_s, rise, fall;
  logic [7:0] data_o;
  logic       done_o, err_o, busy_o;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_lat = -1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s1  <= line;
    s2  <= s1;
    s3  <= s2;
    cyc <= cyc + 1;
  end
  assign in_s = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  uart_rx_core #(.CLK_RATE(16), .BAUD_RATE(1), .DATA_WIDTH(8)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .in_i    (in_s),
    .rise_i  (rise),
    .fall_i  (fall),
    .data_o  (data_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .busy_o  (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (fall && !busy_o && !reset) start_cyc = cyc;
    if (!reset && (done_o || err_o)) begin
      check("done_and_err_exclusive", {31'd0, done_o & err_o}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_event", {30'd0, done_o, err_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_kind", {31'd0, err_o}, {31'd0, e.is_err});
        check("event_data", {24'd0, data_o}, {24'd0, e.data});
        if (done_o) last_lat = cyc - start_cyc - 1;
      end
    end
  end

  task automatic hold(input logic v, input int n);
    line = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit jitter);
    hold(1'b0, BITLEN);
    for (int i = 0; i < 8; i++)
      hold(d[i], jitter ? int'($urandom_range(14, 18)) : BITLEN);
    hold(stop, BITLEN);
    line = 1'b1;
  endtask

  task automatic expect_done(input logic [7:0] d);
    sb.push_back('{is_err: 1'b0, data: d});
  endtask

  task automatic expect_err(input logic [7:0] d);
    sb.push_back('{is_err: 1'b1, data: d});
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;

    repeat (3) @(negedge clk);
    #1;
    check("reset_data", {24'd0, data_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_err",  {31'd0, err_o},  32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    hold(1'b1, 10);

    // 1: clean frame with latency check
    expect_done(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_drain("drain_a5", 100);
    check("latency_a5", {31'd0, (last_lat >= 151 && last_lat <= 153)}, 32'd1);
    check("data_after_a5", {24'd0, data_o}, 32'h0000_00A5);
    hold(1'b1, 20);

    // 2: short low glitch in idle
    line = 1'b0;
    repeat (3) @(negedge clk);
    line = 1'b1;
    busy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
    end
    check("glitch_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
    check("glitch_busy_max9", {31'd0, busy_cnt <= 9}, 32'd1);
    check("glitch_idle", {31'd0, busy_o}, 32'd0);

    // 3: framing error keeps previous data
    expect_err(8'hA5);
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_drain("drain_3c_err", 100);
    check("data_after_err", {24'd0, data_o}, 32'h0000_00A5);
    hold(1'b1, 20);

    // 4: jittered bit lengths
    expect_done(8'h55);
    send_frame(8'h55, 1'b1, 1'b1);
    wait_drain("drain_55", 100);
    hold(1'b1, 20);

    // 5: back-to-back frames
    expect_done(8'h01);
    expect_done(8'hFF);
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_drain("drain_b2b", 100);
    check("data_after_b2b", {24'd0, data_o}, 32'h0000_00FF);
    hold(1'b1, 20);

    // 6: reset during bit 4, then a clean frame
    hold(1'b0, BITLEN * 5 + 8);
    check("busy_before_reset", {31'd0, busy_o}, 32'd1);
    reset = 1'b1;
    #1;
    check("busy_in_reset", {31'd0, busy_o}, 32'd0);
    check("data_in_reset", {24'd0, data_o}, 32'd0);
    hold(1'b1, 4);
    reset = 1'b0;
    hold(1'b1, 30);
    check("idle_after_reset", {31'd0, busy_o}, 32'd0);
    expect_done(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_drain("drain_81", 100);
    check("data_after_81", {24'd0, data_o}, 32'h0000_0081);
    hold(1'b1, 40);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
